// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default sizing for the bit-serial subtractor.
package sub_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam int W_DEF = 8;
    localparam int CNT_W = $clog2(W_DEF);
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle between a producer and the subtractor.
interface serial_subtractor_if #(parameter int W = 8);
    logic         in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
    logic [W-1:0] a, b, d;
    modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, d, bout, ovf);
    modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, d, bout, ovf);
endinterface

// File: rtl/fs_behave.sv
// fs_behave: one-bit full subtractor, diff = x - y - bi with borrow out.
module fs_behave (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock behind valid/ready.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = W_DEF
) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave s
);
    localparam int CW = $clog2(W);
    state_t state, state_n;
    logic [W-1:0]  sa, sb, dreg;
    logic [CW-1:0] cnt;
    logic          borrow, a_sign, b_sign, bout_q, ovf_q, diff, bo, last;
    assign last = cnt == CW'(W - 1);
    fs_behave u_fs (.x(sa[0]), .y(sb[0]), .bi(borrow), .diff(diff), .bo(bo));
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (s.in_valid ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  state == DONE ? (s.out_ready ? IDLE : DONE) : IDLE;
    end
    // bout/ovf are captured on the final bit so they hold the last result while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            dreg   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == IDLE && s.in_valid) begin
            sa     <= s.a;
            sb     <= s.b;
            a_sign <= s.a[W-1];
            b_sign <= s.b[W-1];
            borrow <= s.bin;
            cnt    <= '0;
        end else if (state == BUSY) begin
            dreg   <= {diff, dreg[W-1:1]};
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            borrow <= bo;
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout_q <= bo;
                ovf_q  <= (a_sign != b_sign) & (diff != a_sign);
            end
        end
    end
    assign s.in_ready  = state == IDLE;
    assign s.out_valid = state == DONE;
    assign s.d         = dreg;
    assign s.bout      = bout_q;
    assign s.ovf       = ovf_q;
endmodule
